lvdc_core: RTL and testbench

- Multicycle CPU in the style of the Saturn Launch Vehicle Digital Computer.
- 26-bit data words; two 13-bit instruction syllables per word; 15-bit word address.
- Single port to an external 32K x 26 memory. Reads are combinational. Writes are synchronous on posedge when mem_wen is high.
- Top-level compute block; the memory array is owned by the enclosing system.

---
 rtl/lvdc_core.sv | 170 +++++++++++++++++
 tb/tb_lvdc_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvdc_core.sv
// lvdc_core: multicycle LVDC-style CPU with a single combinational-read, synchronous-write memory port.
// Define LVDC_IRUPT_EN to build in the interrupt entry path (IRQ_SAVE / IRQ_LOAD states).
module lvdc_core #(
  parameter logic [14:0] RESET_ADDR    = 15'h0000,
  parameter logic [14:0] IRQ_SAVE_ADDR = 15'h0002,
  parameter logic [14:0] IRQ_VEC_ADDR  = 15'h0003
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] mem_addr,
  input  logic [25:0] mem_rval,
  output logic [25:0] mem_wval,
  output logic        mem_wen,
  input  logic        irupt
);

`ifdef LVDC_IRUPT_EN
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_IRQ_SAVE, S_IRQ_LOAD} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_EXEC} state_t;
`endif

  typedef enum logic [3:0] {
    OP_HOP = 4'd0,  OP_MPY = 4'd1,  OP_SUB = 4'd2,  OP_DIV = 4'd3,
    OP_TNZ = 4'd4,  OP_MPH = 4'd5,  OP_AND = 4'd6,  OP_ADD = 4'd7,
    OP_TRA = 4'd8,  OP_XOR = 4'd9,  OP_PIO = 4'd10, OP_STO = 4'd11,
    OP_TMI = 4'd12, OP_RSU = 4'd13, OP_SHF = 4'd14, OP_CLA = 4'd15
  } op_t;

  localparam logic [6:0] RESID_SEC = 7'o17;

  state_t      state;
  logic [25:0] acc;
  logic [6:0]  ins_sec;
  logic [7:0]  loc;
  logic        syl;
  logic [6:0]  dat_sec;
  logic [12:0] ir;
  logic        insvc;

  op_t         opcode;
  logic [8:0]  operand;
  logic [14:0] pc;
  logic [14:0] ea;
  logic [25:0] shifted;

  assign opcode  = op_t'(ir[12:9]);
  assign operand = ir[8:0];
  assign pc      = {ins_sec, loc};
  assign ea      = operand[8] ? {RESID_SEC, operand[7:0]} : {dat_sec, operand[7:0]};

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    shifted = acc;
    if (operand[4]) shifted = acc << operand[1:0];
    else            shifted = $signed(acc) >>> operand[1:0];
  end

  always_comb begin
    mem_addr = pc;
    mem_wen  = 1'b0;
    mem_wval = acc;
    case (state)
      S_FETCH: mem_addr = pc;
      S_EXEC: begin
        mem_addr = ea;
        mem_wen  = (opcode == OP_STO);
      end
`ifdef LVDC_IRUPT_EN
      S_IRQ_SAVE: begin
        mem_addr = IRQ_SAVE_ADDR;
        mem_wen  = 1'b1;
        mem_wval = {3'b000, dat_sec, syl, ins_sec, loc};
      end
      S_IRQ_LOAD: mem_addr = IRQ_VEC_ADDR;
`endif
      default: mem_addr = pc;
    endcase
  end

`ifndef LVDC_IRUPT_EN
  logic unused_irq;
  assign unused_irq = ^{irupt, insvc, IRQ_SAVE_ADDR, IRQ_VEC_ADDR};
`endif

  // NOTE: state registers use non-blocking assignments; a later assignment in the same block wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      acc     <= '0;
      ins_sec <= RESET_ADDR[14:8];
      loc     <= RESET_ADDR[7:0];
      syl     <= 1'b0;
      dat_sec <= '0;
      ir      <= '0;
      insvc   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= syl ? mem_rval[25:13] : mem_rval[12:0];
          syl   <= ~syl;
          if (syl) loc <= loc + 8'd1;
          state <= S_EXEC;
`ifdef LVDC_IRUPT_EN
          // Interrupt preempts the fetch: PC stays on the not-yet-fetched syllable.
          if (irupt && !insvc) begin
            ir    <= ir;
            syl   <= syl;
            loc   <= loc;
            state <= S_IRQ_SAVE;
          end
`endif
        end

        S_EXEC: begin
          state <= S_FETCH;
          case (opcode)
            OP_HOP: begin
              ins_sec <= mem_rval[14:8];
              loc     <= mem_rval[7:0];
              syl     <= mem_rval[15];
              dat_sec <= mem_rval[22:16];
              insvc   <= 1'b0;
            end
            OP_MPY: acc <= acc * mem_rval;
            OP_SUB: acc <= acc - mem_rval;
            OP_TNZ: if (acc != '0) begin
              loc <= operand[7:0];
              syl <= operand[8];
            end
            OP_AND: acc <= acc & mem_rval;
            OP_ADD: acc <= acc + mem_rval;
            OP_TRA: begin
              loc <= operand[7:0];
              syl <= operand[8];
            end
            OP_XOR: acc <= acc ^ mem_rval;
            OP_TMI: if (acc[25]) begin
              loc <= operand[7:0];
              syl <= operand[8];
            end
            OP_RSU: acc <= mem_rval - acc;
            OP_SHF: begin
              if (operand[8]) dat_sec <= operand[6:0];
              else            acc     <= shifted;
            end
            OP_CLA: acc <= mem_rval;
            default: ;  // DIV, MPH, PIO, STO leave registers untouched
          endcase
        end

`ifdef LVDC_IRUPT_EN
        S_IRQ_SAVE: state <= S_IRQ_LOAD;

        S_IRQ_LOAD: begin
          ins_sec <= mem_rval[14:8];
          loc     <= mem_rval[7:0];
          syl     <= mem_rval[15];
          dat_sec <= mem_rval[22:16];
          insvc   <= 1'b1;
          state   <= S_FETCH;
        end
`endif

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_lvdc_core.sv
// tb_lvdc_core: instruction-level reference model predicting every bus cycle of lvdc_core,
// plus directed programs with hand-computed memory results.
module tb_lvdc_core;

  localparam logic [14:0] IRQ_SAVE = 15'h0002;
  localparam logic [14:0] IRQ_VEC  = 15'h0003;
  localparam int OP_HOP = 0, OP_MPY = 1, OP_SUB = 2, OP_TNZ = 4, OP_AND = 6, OP_ADD = 7;
  localparam int OP_TRA = 8, OP_XOR = 9, OP_STO = 11, OP_TMI = 12, OP_RSU = 13, OP_SHF = 14, OP_CLA = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] mem_addr;
  logic [25:0] mem_rval;
  logic [25:0] mem_wval;
  logic        mem_wen;
  logic        irupt;

  logic [25:0] mem [0:32767];  // memory seen by the DUT
  logic [25:0] mm  [0:32767];  // model's memory

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  logic chk_en = 1'b0;

  typedef struct {
    logic [14:0] addr;
    logic        wen;
    logic [25:0] wval;
  } bus_t;
  bus_t exp_q[$];
  bus_t e;

  logic [25:0] m_acc;
  logic [6:0]  m_is, m_ds;
  logic [7:0]  m_loc;
  logic        m_syl, m_insvc;

  lvdc_core dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_rval (mem_rval),
    .mem_wval (mem_wval),
    .mem_wen  (mem_wen),
    .irupt    (irupt)
  );

  always #5 clk = ~clk;

  assign mem_rval = mem[mem_addr];
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wval;
  always @(posedge clk) if (!rst && mem_wen) wen_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] sy(input int op, input int opd);
    return {4'(op), 9'(opd)};
  endfunction

  task automatic put(input int a, input logic [25:0] v);
    mem[a] = v;
    mm[a]  = v;
  endtask

  task automatic put2(input int a, input logic [12:0] s0, input logic [12:0] s1);
    put(a, {s1, s0});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc = '0; m_is = '0; m_loc = '0; m_syl = 1'b0; m_ds = '0; m_insvc = 1'b0;
  endtask

  task automatic model_hop(input logic [25:0] m);
    m_is  = m[14:8];
    m_loc = m[7:0];
    m_syl = m[15];
    m_ds  = m[22:16];
  endtask

  // Executes one whole instruction (or interrupt entry) and queues the bus cycles it must produce.
  task automatic model_step();
    logic [14:0] pc, ea;
    logic [25:0] w, m;
    logic [12:0] ins;
    logic [8:0]  opd;
    int          op, sv;
    longint      prod;
    pc = {m_is, m_loc};
`ifdef LVDC_IRUPT_EN
    if (irupt && !m_insvc) begin
      exp_q.push_back('{pc, 1'b0, 26'd0});
      exp_q.push_back('{IRQ_SAVE, 1'b1, {3'b000, m_ds, m_syl, m_is, m_loc}});
      exp_q.push_back('{IRQ_VEC, 1'b0, 26'd0});
      model_hop(mm[IRQ_VEC]);
      m_insvc = 1'b1;
      return;
    end
`endif
    w   = mm[pc];
    ins = m_syl ? w[25:13] : w[12:0];
    if (m_syl) begin
      m_syl = 1'b0;
      m_loc = m_loc + 8'd1;
    end else begin
      m_syl = 1'b1;
    end
    op  = int'(ins[12:9]);
    opd = ins[8:0];
    ea  = opd[8] ? {7'o17, opd[7:0]} : {m_ds, opd[7:0]};
    m   = mm[ea];
    exp_q.push_back('{pc, 1'b0, 26'd0});
    exp_q.push_back('{ea, op == OP_STO, m_acc});
    case (op)
      OP_HOP: begin model_hop(m); m_insvc = 1'b0; end
      OP_MPY: begin prod = longint'(m_acc) * longint'(m); m_acc = prod[25:0]; end
      OP_SUB: m_acc = m_acc - m;
      OP_TNZ: if (m_acc != 0) begin m_loc = opd[7:0]; m_syl = opd[8]; end
      OP_AND: m_acc = m_acc & m;
      OP_ADD: m_acc = m_acc + m;
      OP_TRA: begin m_loc = opd[7:0]; m_syl = opd[8]; end
      OP_XOR: m_acc = m_acc ^ m;
      OP_TMI: if (m_acc[25]) begin m_loc = opd[7:0]; m_syl = opd[8]; end
      OP_RSU: m_acc = m - m_acc;
      OP_SHF: begin
        if (opd[8]) m_ds = opd[6:0];
        else if (opd[4]) m_acc = 26'(m_acc * (26'd1 << opd[1:0]));
        else begin
          sv = int'($signed(m_acc));
          sv = sv >>> opd[1:0];
          m_acc = 26'(sv);
        end
      end
      OP_CLA: m_acc = m;
      default: ;
    endcase
  endtask

  // One bus comparison per cycle; model memory updates when the write cycle is reached.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (exp_q.size() == 0) model_step();
      e = exp_q.pop_front();
      check("bus", {22'd0, mem_addr, mem_wen, mem_wen ? mem_wval : 26'd0},
                   {22'd0, e.addr, e.wen, e.wen ? e.wval : 26'd0});
      if (e.wen) mm[e.addr] = e.wval;
    end
  end

  task automatic hold_reset();
    rst = 1'b1;
    chk_en = 1'b0;
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) put(i, 26'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    check("rst_addr", 64'(mem_addr), 64'(15'h0000));
    check("rst_wen", 64'(mem_wen), 64'd0);
    check("rst_wval", 64'(mem_wval), 64'd0);
    model_reset();
    wen_cnt = 0;
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [25:0] c0;
  int nmis;

  initial begin
    irupt = 1'b0;

    // CLA/ADD/STO: result lands after six cycles with a single write strobe
    hold_reset(); clear_mem();
    put2(0, sy(OP_CLA, 'h10), sy(OP_ADD, 'h11));
    put2(1, sy(OP_STO, 'h12), sy(OP_TRA, 'h101));
    put('h10, 26'd5); put('h11, 26'd7);
    release_reset();
    run(5);
    check("sto_early", 64'(mem['h12]), 64'd0);
    run(1);
    check("sto_dut", 64'(mem['h12]), 64'd12);
    check("sto_model", 64'(mm['h12]), 64'd12);
    run(10);
    check("wen_once", 64'(wen_cnt), 64'd1);

    // SUB/RSU with TMI taken after SUB and not after RSU
    hold_reset(); clear_mem();
    put2(0, sy(OP_CLA, 'h10), sy(OP_SUB, 'h11));
    put2(1, sy(OP_STO, 'h20), sy(OP_TMI, 'h003));
    put2(2, sy(OP_CLA, 'h13), sy(OP_STO, 'h22));
    put2(3, sy(OP_CLA, 'h10), sy(OP_RSU, 'h11));
    put2(4, sy(OP_STO, 'h23), sy(OP_TMI, 'h006));
    put2(5, sy(OP_CLA, 'h14), sy(OP_STO, 'h24));
    put2(6, sy(OP_TRA, 'h006), sy(OP_TRA, 'h006));
    put('h10, 26'd3); put('h11, 26'd5); put('h13, 26'h0BAD); put('h14, 26'h600D);
    release_reset();
    run(30);
    check("sub", 64'(mem['h20]), 64'(26'h3FFFFFE));
    check("sub_model", 64'(mm['h20]), 64'(26'h3FFFFFE));
    check("tmi_taken", 64'(mem['h22]), 64'd0);
    check("rsu", 64'(mem['h23]), 64'd2);
    check("tmi_fall", 64'(mem['h24]), 64'(26'h600D));

    // TNZ loop: three passes, then falls through to STO of zero at cycle 16
    hold_reset(); clear_mem();
    put2(0, sy(OP_CLA, 'h10), sy(OP_ADD, 'h11));
    put2(1, sy(OP_TNZ, 'h100), sy(OP_STO, 'h14));
    put2(2, sy(OP_TRA, 'h002), sy(OP_TRA, 'h002));
    put('h10, 26'd3); put('h11, 26'h3FFFFFF); put('h14, 26'h1234);
    release_reset();
    run(15);
    check("tnz_loop", 64'(mem['h14]), 64'(26'h1234));
    run(1);
    check("tnz_exit", 64'(mem['h14]), 64'd0);

    // HOP into sector 1 with DS=5; data and residual sector addressing
    hold_reset(); clear_mem();
    put2(0, sy(OP_HOP, 'h010), sy(OP_TRA, 'h000));
    put('h10, 26'h0050120);
    put2('h120, sy(OP_CLA, 'h001), sy(OP_STO, 'h002));
    put2('h121, sy(OP_CLA, 'h101), sy(OP_STO, 'h003));
    put2('h122, sy(OP_TRA, 'h022), sy(OP_TRA, 'h022));
    put('h501, 26'h0ABC); put('hF01, 26'h0777);
    release_reset();
    run(2);
    @(negedge clk);
    check("hop_target", 64'(mem_addr), 64'(15'h0120));
    @(negedge clk);
    check("ds_ea", 64'(mem_addr), 64'(15'h0501));
    run(16);
    check("ds_read", 64'(mem['h502]), 64'(26'h0ABC));
    check("resid_read", 64'(mem['h503]), 64'(26'h0777));

    // SHF: arithmetic right by 1, then left by 2
    hold_reset(); clear_mem();
    put2(0, sy(OP_CLA, 'h10), sy(OP_SHF, 'h001));
    put2(1, sy(OP_STO, 'h20), sy(OP_CLA, 'h10));
    put2(2, sy(OP_SHF, 'h012), sy(OP_STO, 'h21));
    put2(3, sy(OP_TRA, 'h003), sy(OP_TRA, 'h003));
    put('h10, 26'h2000001);
    release_reset();
    run(20);
    check("shr", 64'(mem['h20]), 64'(26'h3000000));
    check("shl", 64'(mem['h21]), 64'(26'h0000004));
    check("shl_model", 64'(mm['h21]), 64'(26'h0000004));

`ifdef LVDC_IRUPT_EN
    // Interrupt: one entry while in service, then HOP via the save word resumes the counter loop
    hold_reset(); clear_mem();
    put2(0, sy(OP_CLA, 'h20), sy(OP_ADD, 'h10));
    put2(1, sy(OP_STO, 'h20), sy(OP_TRA, 'h000));
    put('h10, 26'd1); put(3, 26'h0000040);
    put2('h40, sy(OP_CLA, 'h21), sy(OP_ADD, 'h10));
    put2('h41, sy(OP_STO, 'h21), sy(OP_HOP, 'h002));
    release_reset();
    run(10);
    c0 = mem['h20];
    #1 irupt = 1'b1;
    run(4);
    #1 irupt = 1'b0;
    run(40);
    check("irq_once", 64'(mem['h21]), 64'd1);
    check("irq_once_model", 64'(mm['h21]), 64'd1);
    check("irq_save_fmt", 64'(mem[2] & 26'h3FF7F00), 64'd0);
    check("irq_resume", 64'(mem['h20] > c0), 64'd1);
`endif

    // Random memory images, random irupt and occasional mid-instruction resets
    for (int r = 0; r < 3; r++) begin
      hold_reset();
      for (int i = 0; i < 32768; i++) put(i, 26'($urandom));
      release_reset();
      for (int c = 0; c < 3000; c++) begin
        @(posedge clk);
        #1;
        if ($urandom_range(0, 499) == 0) begin
          rst = 1'b1;
          chk_en = 1'b0;
          model_reset();
          @(posedge clk);
          #1;
          rst = 1'b0;
          chk_en = 1'b1;
        end
        #1 irupt = ($urandom_range(0, 15) == 0);
      end
      hold_reset();
      irupt = 1'b0;
      nmis = 0;
      for (int i = 0; i < 32768; i++) if (mem[i] !== mm[i]) nmis++;
      check("mem_image", 64'(nmis), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
